// File: rtl/div_arb_pkg.sv
// rtl/div_arb_pkg.sv - state encoding, default sizes and clog2 helper for the divider-sharing arbiter
package div_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } arb_state_e;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_W     = 20;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector: first asserted request after the pointer, with wrap
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    localparam logic [IW:0] N_L = (IW+1)'(N);

    logic [IW:0] pos;

    // Scan ptr+1 .. ptr+N so the last winner has the lowest priority next time.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = '0;
        for (int k = 1; k <= N; k++) begin
            pos = {1'b0, ptr_i} + (IW+1)'(k);
            if (pos >= N_L) begin
                pos = pos - N_L;
            end
            if (!valid_o && req_i[pos[IW-1:0]]) begin
                valid_o             = 1'b1;
                idx_o               = pos[IW-1:0];
                gnt_o[pos[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - shares one iterative divider among N_REQ requesters, round-robin
// Optional zero-divisor bypass (div_zero output) when DIV_ARB_ZERO_BYPASS_EN is defined.
module div_share_arbiter
    import div_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    parameter int IW    = clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] dvnd_flat,
    input  logic [N_REQ*W-1:0] dvsr_flat,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       quo_out,
    output logic [W-1:0]       rmd_out,
    output logic               busy,
`ifdef DIV_ARB_ZERO_BYPASS_EN
    output logic               div_zero,
`endif
    output logic               div_start,
    output logic [W-1:0]       div_dvnd,
    output logic [W-1:0]       div_dvsr,
    input  logic               div_ready,
    input  logic               div_done_tick,
    input  logic [W-1:0]       div_quo,
    input  logic [W-1:0]       div_rmd
);

    arb_state_e       state_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    owner_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] done_q;
    logic             start_q;
    logic [W-1:0]     quo_q;
    logic [W-1:0]     rmd_q;
    logic [W-1:0]     dvnd_q;
    logic [W-1:0]     dvsr_q;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    logic             bypass_q;
    logic             zero_q;
`endif

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [W-1:0]     win_dvnd;
    logic [W-1:0]     win_dvsr;
    logic [N_REQ-1:0] owner_onehot;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign win_dvnd     = dvnd_flat[int'(pick_idx) * W +: W];
    assign win_dvsr     = dvsr_flat[int'(pick_idx) * W +: W];
    assign owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= IW'(N_REQ - 1);
            owner_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            start_q  <= 1'b0;
            quo_q    <= '0;
            rmd_q    <= '0;
            dvnd_q   <= '0;
            dvsr_q   <= '0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
            bypass_q <= 1'b0;
            zero_q   <= 1'b0;
`endif
        end else begin
            gnt_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
            zero_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (pick_valid && div_ready) begin
                        gnt_q   <= pick_gnt;
                        owner_q <= pick_idx;
                        ptr_q   <= pick_idx;
                        dvnd_q  <= win_dvnd;
                        dvsr_q  <= win_dvsr;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                        if (win_dvsr == '0) begin
                            bypass_q <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_START;
                        end
`else
                        state_q <= S_START;
`endif
                    end
                end
                S_START: begin
                    start_q <= 1'b1;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_done_tick) begin
                        quo_q   <= div_quo;
                        rmd_q   <= div_rmd;
                        done_q  <= owner_onehot;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
`ifdef DIV_ARB_ZERO_BYPASS_EN
                    // Bypassed ops spend an extra DONE cycle so done lands one cycle after gnt.
                    if (bypass_q) begin
                        bypass_q <= 1'b0;
                        quo_q    <= '1;
                        rmd_q    <= dvnd_q;
                        done_q   <= owner_onehot;
                        zero_q   <= 1'b1;
                    end else begin
                        state_q  <= S_IDLE;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign quo_out   = quo_q;
    assign rmd_out   = rmd_q;
    assign busy      = (state_q != S_IDLE);
    assign div_start = start_q;
    assign div_dvnd  = dvnd_q;
    assign div_dvsr  = dvsr_q;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    assign div_zero  = zero_q;
`endif

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - scoreboard bench for div_share_arbiter with a behavioural divider
module tb_div_share_arbiter;

    localparam int N       = 4;
    localparam int W       = 20;
    localparam int LAT     = 5;
    localparam int DIV_LAT = LAT + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req;
    logic [N*W-1:0] dvnd_flat;
    logic [N*W-1:0] dvsr_flat;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   quo_out;
    logic [W-1:0]   rmd_out;
    logic           busy;
    logic           div_start;
    logic [W-1:0]   div_dvnd;
    logic [W-1:0]   div_dvsr;
    logic           div_ready;
    logic           div_done_tick;
    logic [W-1:0]   div_quo;
    logic [W-1:0]   div_rmd;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    logic           div_zero;
`endif

    always #5 clk = ~clk;

    div_share_arbiter #(.N_REQ(N), .W(W), .IW(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .dvnd_flat     (dvnd_flat),
        .dvsr_flat     (dvsr_flat),
        .gnt           (gnt),
        .done          (done),
        .quo_out       (quo_out),
        .rmd_out       (rmd_out),
        .busy          (busy),
`ifdef DIV_ARB_ZERO_BYPASS_EN
        .div_zero      (div_zero),
`endif
        .div_start     (div_start),
        .div_dvnd      (div_dvnd),
        .div_dvsr      (div_dvsr),
        .div_ready     (div_ready),
        .div_done_tick (div_done_tick),
        .div_quo       (div_quo),
        .div_rmd       (div_rmd)
    );

    // Behavioural iterative divider: start-to-done_tick latency DIV_LAT cycles
    logic         m_busy;
    int           m_cnt;
    logic [W-1:0] m_a, m_b;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy        <= 1'b0;
            m_cnt         <= 0;
            m_a           <= '0;
            m_b           <= '0;
            div_done_tick <= 1'b0;
            div_quo       <= '0;
            div_rmd       <= '0;
        end else begin
            div_done_tick <= 1'b0;
            if (!m_busy) begin
                if (div_start) begin
                    m_busy <= 1'b1;
                    m_cnt  <= LAT;
                    m_a    <= div_dvnd;
                    m_b    <= div_dvsr;
                end
            end else if (m_cnt == 1) begin
                m_busy        <= 1'b0;
                div_done_tick <= 1'b1;
                div_quo       <= (m_b == '0) ? '1 : m_a / m_b;
                div_rmd       <= (m_b == '0) ? m_a : m_a % m_b;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign div_ready = !m_busy;

    typedef struct {
        int           idx;
        logic [W-1:0] quo;
        logic [W-1:0] rmd;
        logic         zero;
    } exp_t;

    exp_t exp_done[$];
    int   exp_gnt[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_gnt_cyc = 0;
    int   last_done_cyc = 0;
    int   n_done = 0;
    int   n_start = 0;
    logic hold_req = 1'b0;

    task automatic cycle();
        exp_t e;
        int   g;
        logic ok;
        @(negedge clk);
        cyc++;
        if (reset) return;
        if (div_start === 1'b1) n_start++;
        if (gnt !== '0) begin
            last_gnt_cyc = cyc;
            n_checks++;
            if (exp_gnt.size() == 0) begin
                $display("FAIL gnt_unexpected: got %b, expected no grant", gnt);
            end else begin
                g = exp_gnt.pop_front();
                if (gnt !== (N'(1) << g)) $display("FAIL gnt_order: got %b, expected %b", gnt, N'(1) << g);
                else n_pass++;
            end
        end
        if (done !== '0) begin
            last_done_cyc = cyc;
            n_done++;
            n_checks++;
            if (exp_done.size() == 0) begin
                $display("FAIL done_unexpected: got %b, expected no done", done);
            end else begin
                e  = exp_done.pop_front();
                ok = (done === (N'(1) << e.idx)) && (quo_out === e.quo) && (rmd_out === e.rmd);
`ifdef DIV_ARB_ZERO_BYPASS_EN
                ok = ok && (div_zero === e.zero);
`endif
                if (!ok) $display("FAIL done_result: got done=%b quo=%0d rmd=%0d, expected done=%b quo=%0d rmd=%0d",
                                  done, quo_out, rmd_out, N'(1) << e.idx, e.quo, e.rmd);
                else n_pass++;
            end
            if (!hold_req) req = req & ~done;
        end
    endtask

    task automatic run_idle(input int budget, input string name);
        int k;
        k = 0;
        while ((exp_done.size() != 0 || exp_gnt.size() != 0 || busy !== 1'b0 || req !== '0) && k < budget) begin
            cycle();
            k++;
        end
        n_checks++;
        if (exp_done.size() != 0 || busy !== 1'b0) $display("FAIL %s_timeout: %0d results pending busy=%b after %0d cycles, expected 0 pending",
                                                           name, exp_done.size(), busy, budget);
        else n_pass++;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        dvnd_flat[i*W +: W] = a;
        dvsr_flat[i*W +: W] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_done.delete();
        exp_gnt.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({gnt, done, busy, div_start} !== '0) $display("FAIL reset_ctrl: got gnt=%b done=%b busy=%b start=%b, expected all 0", gnt, done, busy, div_start);
        else n_pass++;
        n_checks++;
        if (quo_out !== '0 || rmd_out !== '0 || div_dvnd !== '0 || div_dvsr !== '0)
            $display("FAIL reset_data: got quo=%0d rmd=%0d dvnd=%0d dvsr=%0d, expected 0", quo_out, rmd_out, div_dvnd, div_dvsr);
        else n_pass++;
        reset = 1'b0;
        cycle();
        n_checks++;
        if (busy !== 1'b0 || gnt !== '0) $display("FAIL reset_idle: got busy=%b gnt=%b, expected 0", busy, gnt);
        else n_pass++;
    endtask

    task automatic test_single();
        set_op(0, 20'd1000000, 20'd400);
        exp_gnt.push_back(0);
        exp_done.push_back('{0, 20'd2500, 20'd0, 1'b0});
        n_start = 0;
        req = 4'b0001;
        cycle();
        n_checks++;
        if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b, expected 0001", gnt);
        else n_pass++;
        cycle();
        n_checks++;
        if (div_start !== 1'b1 || div_dvnd !== 20'd1000000 || div_dvsr !== 20'd400)
            $display("FAIL single_start: got start=%b dvnd=%0d dvsr=%0d, expected 1 1000000 400", div_start, div_dvnd, div_dvsr);
        else n_pass++;
        run_idle(60, "single");
        n_checks++;
        if (last_done_cyc - last_gnt_cyc !== DIV_LAT + 2)
            $display("FAIL single_latency: got %0d, expected %0d", last_done_cyc - last_gnt_cyc, DIV_LAT + 2);
        else n_pass++;
        n_checks++;
        if (n_start !== 1) $display("FAIL single_start_count: got %0d, expected 1", n_start);
        else n_pass++;
        cycle();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL single_busy: got %b, expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_op(1, 20'd1000000, 20'd3);
        set_op(2, 20'd1000000, 20'd7);
        set_op(3, 20'd1000000, 20'd1000);
        exp_gnt.push_back(1);
        exp_gnt.push_back(2);
        exp_gnt.push_back(3);
        exp_done.push_back('{1, 20'd333333, 20'd1, 1'b0});
        exp_done.push_back('{2, 20'd142857, 20'd1, 1'b0});
        exp_done.push_back('{3, 20'd1000,   20'd0, 1'b0});
        req = 4'b1110;
        run_idle(200, "simultaneous");
    endtask

    task automatic test_fairness();
        int k;
        int a;
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, W'(900000 + i * 1111), W'(i + 3));
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                a = 900000 + i * 1111;
                exp_gnt.push_back(i);
                exp_done.push_back('{i, W'(a / (i + 3)), W'(a % (i + 3)), 1'b0});
            end
        end
        hold_req = 1'b1;
        n_done   = 0;
        req      = 4'b1111;
        k        = 0;
        while (n_done < 8 && k < 400) begin
            cycle();
            k++;
        end
        req      = '0;
        hold_req = 1'b0;
        n_checks++;
        if (n_done !== 8) $display("FAIL fairness_count: got %0d dones, expected 8", n_done);
        else n_pass++;
        run_idle(100, "fairness");
    endtask

    task automatic test_drop_after_grant();
        int k;
        set_op(2, 20'd999999, 20'd9);
        exp_gnt.push_back(2);
        exp_done.push_back('{2, 20'd111111, 20'd0, 1'b0});
        req = 4'b0100;
        k = 0;
        do begin
            cycle();
            k++;
        end while (gnt !== 4'b0100 && k < 20);
        n_checks++;
        if (gnt !== 4'b0100) $display("FAIL drop_gnt: got %b, expected 0100", gnt);
        else n_pass++;
        set_op(2, 20'd12345, 20'd5);
        cycle();
        cycle();
        cycle();
        req = '0;
        run_idle(60, "drop");
    endtask

    task automatic test_reset_mid();
        int k;
        set_op(1, 20'd777777, 20'd11);
        exp_gnt.push_back(1);
        exp_done.push_back('{1, 20'd70707, 20'd0, 1'b0});
        req = 4'b0010;
        k = 0;
        do begin
            cycle();
            k++;
        end while (div_start !== 1'b1 && k < 20);
        cycle();
        cycle();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({gnt, done, busy, div_start} !== '0) $display("FAIL midreset_ctrl: got gnt=%b done=%b busy=%b start=%b, expected all 0", gnt, done, busy, div_start);
        else n_pass++;
        n_checks++;
        if (quo_out !== '0 || rmd_out !== '0 || div_dvnd !== '0 || div_dvsr !== '0)
            $display("FAIL midreset_data: got quo=%0d rmd=%0d dvnd=%0d dvsr=%0d, expected 0", quo_out, rmd_out, div_dvnd, div_dvsr);
        else n_pass++;
        exp_done.delete();
        exp_gnt.delete();
        req = '0;
        cycle();
        cycle();
        reset  = 1'b0;
        n_done = 0;
        repeat (15) cycle();
        n_checks++;
        if (n_done !== 0) $display("FAIL midreset_no_done: got %0d dones, expected 0", n_done);
        else n_pass++;
        exp_gnt.push_back(1);
        exp_done.push_back('{1, 20'd70707, 20'd0, 1'b0});
        req = 4'b0010;
        run_idle(60, "after_reset");
    endtask

`ifdef DIV_ARB_ZERO_BYPASS_EN
    task automatic test_zero_bypass();
        set_op(0, 20'd500, 20'd0);
        exp_gnt.push_back(0);
        exp_done.push_back('{0, 20'hFFFFF, 20'd500, 1'b1});
        n_start = 0;
        req = 4'b0001;
        cycle();
        n_checks++;
        if (gnt !== 4'b0001) $display("FAIL zero_gnt: got %b, expected 0001", gnt);
        else n_pass++;
        cycle();
        n_checks++;
        if (done !== 4'b0001 || div_zero !== 1'b1) $display("FAIL zero_latency: got done=%b div_zero=%b, expected 0001 1", done, div_zero);
        else n_pass++;
        run_idle(20, "zero");
        n_checks++;
        if (n_start !== 0) $display("FAIL zero_no_start: got %0d starts, expected 0", n_start);
        else n_pass++;
    endtask
`endif

    initial begin
        req       = '0;
        dvnd_flat = '0;
        dvsr_flat = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_drop_after_grant();
        test_reset_mid();
`ifdef DIV_ARB_ZERO_BYPASS_EN
        test_zero_bypass();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Round-robin scheduler that shares one iterative divider (start/done_tick handshake, W-bit dvnd/dvsr, quo/rmd) among N_REQ requesters.
- Example requesters: frequency-counter front ends that each need 1,000,000/period.
- Latches the winner's operands, sequences the divider, and routes quo/rmd back with a one-hot done pulse.
- Sits between the measurement FSMs and a single div instance; the divider uses the same clk/reset.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 20, operand/result width; must match the divider's W.
- IW, 2, requester index width = clog2(N_REQ).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- req  in  N_REQ  per-requester request level
- dvnd_flat  in  N_REQ*W  dividends; requester i occupies bits [i*W +: W]
- dvsr_flat  in  N_REQ*W  divisors, same packing
- gnt  out  N_REQ  one-hot, one-cycle pulse; operands sampled this cycle
- done  out  N_REQ  one-hot, one-cycle pulse; result valid this cycle
- quo_out  out  W  quotient, held until next done
- rmd_out  out  W  remainder, held until next done
- busy  out  1  high in every state except IDLE
- div_start  out  1  one-cycle start to divider
- div_dvnd  out  W  registered dividend to divider
- div_dvsr  out  W  registered divisor to divider
- div_ready  in  1  divider idle
- div_done_tick  in  1  divider completion pulse
- div_quo  in  W  divider quotient
- div_rmd  in  W  divider remainder

Behaviour:
- Reset: state=IDLE, last-grant pointer=N_REQ-1 (req[0] has top priority first); gnt, done, div_start, busy = 0; quo_out, rmd_out, div_dvnd, div_dvsr, owner = 0.
- State IDLE:
  - If |req and div_ready, pick the first asserted req scanning from pointer+1 upward with wrap.
  - Pulse gnt[winner], register dvnd/dvsr into div_dvnd/div_dvsr, store owner=winner, update pointer=winner, go START.
  - If div_ready=0, no grant.
- State START: div_start=1 for exactly one cycle, then go WAIT.
- State WAIT: on div_done_tick, register div_quo→quo_out and div_rmd→rmd_out, go DONE.
- State DONE: done[owner]=1 for one cycle, go IDLE.
- Latency and throughput:
  - gnt to div_start: 1 cycle.
  - div_done_tick to done: 1 cycle.
  - gnt cycle to done cycle = divider latency + 2.
  - Minimum gap between done and the next gnt: 1 cycle (IDLE is visited).
- Handshake:
  - Requester holds req until its done pulse.
  - req dropped before grant withdraws the request.
  - req dropped after grant has no effect; the operation completes and done is still pulsed.
  - req held high after done is treated as a new request.
- Fairness: any continuously asserted req is granted within N_REQ operations.
- div_done_tick outside WAIT is ignored.
- Operand changes after gnt are ignored.
- Reset mid-operation: immediate return to IDLE with reset values. No done is issued for the aborted operation.
- Division by zero is passed to the divider unchanged (divider-defined result) unless the optional feature is compiled in.

Optional Feature:
- Macro DIV_ARB_ZERO_BYPASS_EN.
- Defined: in IDLE, a winner with dvsr==0 is still granted, but the block skips START/WAIT and goes straight to DONE.
  - Sets quo_out = all ones and rmd_out = the dividend.
  - Adds a 1-bit output div_zero that pulses with done.
  - div_start is not asserted for that operation.
  - Latency gnt→done = 1 cycle.
- Undefined: no div_zero port; zero divisors are handled as in Behaviour.

Decomposition:
- Package div_arb_pkg holds:
  - state enum IDLE/START/WAIT/DONE (2-bit encoding);
  - default N_REQ and W constants;
  - a clog2 function for IW.
- One natural sub-module: rr_pick, a combinational round-robin selector. Inputs are req and pointer; outputs are a one-hot grant and the binary index. It is reusable by other shared units (bin2bcd sharing).

Test Plan (N_REQ=4, W=20, real 20-bit divider):
- Single request: req[0], dvnd=1000000, dvsr=400 → gnt[0] in 1 cycle, div_start next cycle, done[0] with quo=2500, rmd=0; busy low after.
- Simultaneous req[1], req[2], req[3] from reset → grant order 1,2,3. Results are routed to the matching done bits:
  - dvsr 3 → 333333 r1
  - dvsr 7 → 142857 r1
  - dvsr 1000 → 1000 r0
- All four req held continuously for 8 operations → grant sequence 0,1,2,3,0,1,2,3; no requester starved.
- req[2] dropped during WAIT → done[2] still pulses with the correct result. Operand change after gnt does not alter the result.
- Reset asserted in WAIT → all outputs 0 the same cycle; no done. A subsequent req[1] is granted normally.
- With DIV_ARB_ZERO_BYPASS_EN: req[0], dvnd=500, dvsr=0 → no div_start; done[0] and div_zero 1 cycle after gnt; quo=0xFFFFF, rmd=500.
